// File: rtl/frame_sched_pkg.sv
// Shared constants and helpers for the vertical-blank update scheduler.
package frame_sched_pkg;

   localparam int unsigned MAX_REQ            = 32;
   localparam int unsigned DEF_N_REQ          = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
   localparam int unsigned DEF_CNT_W          = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ARB   = 2'd1;
   localparam state_t ST_SERVE = 2'd2;

   // One-hot decode of a requester index; callers truncate to their own width.
   function automatic logic [MAX_REQ-1:0] onehot(input logic [7:0] idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set-bit picker: finds the first pending bit at or above rr_ptr,
// wrapping past N_REQ-1 back to 0.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] pending,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [PTR_W-1:0] idx_c,
   output logic             valid_c
);

   logic [PTR_W:0] pos;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      idx_c   = '0;
      valid_c = 1'b0;
      pos     = '0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (pos >= (PTR_W+1)'(N_REQ)) begin
            pos = pos - (PTR_W+1)'(N_REQ);
         end
         if (pending[pos[PTR_W-1:0]]) begin
            idx_c   = pos[PTR_W-1:0];
            valid_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_update_scheduler.sv
// Grants game-logic units exclusive write access to shared sprite/position
// state, one at a time in round-robin order, only during vertical blank.
module frame_update_scheduler
   import frame_sched_pkg::*;
#(
   parameter int unsigned N_REQ          = DEF_N_REQ,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             blank_start,
   input  logic             active_start,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   input  logic             clear_sticky,
   output logic [N_REQ-1:0] grant,
   output logic             frame_tick,
   output logic [CNT_W-1:0] frame_count,
   output logic             busy,
   output logic             timeout,
   output logic             overrun,
   output logic             overrun_sticky
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t           state, state_nxt;
   logic [N_REQ-1:0] pending, pending_nxt;
   logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0] cur_idx, cur_idx_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [N_REQ-1:0] grant_nxt;
   logic             frame_tick_nxt, busy_nxt, timeout_nxt, overrun_nxt, sticky_nxt;
   logic [CNT_W-1:0] frame_count_nxt;

   logic [N_REQ-1:0] cur_mask, remain;
   logic [PTR_W-1:0] idx_inc, pick_idx;
   logic             done_hit, pick_valid;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .pending (pending),
      .rr_ptr  (rr_ptr),
      .idx_c   (pick_idx),
      .valid_c (pick_valid)
   );

   // Next-state and next-output logic; active_start abort overrides everything.
   always_comb begin
      state_nxt       = state;
      pending_nxt     = pending;
      rr_ptr_nxt      = rr_ptr;
      cur_idx_nxt     = cur_idx;
      timer_nxt       = timer;
      grant_nxt       = grant;
      frame_tick_nxt  = 1'b0;
      frame_count_nxt = frame_count;
      timeout_nxt     = 1'b0;
      overrun_nxt     = 1'b0;
      remain          = pending;
      cur_mask        = N_REQ'(onehot(8'(cur_idx)));
      idx_inc         = (cur_idx == PTR_W'(N_REQ - 1)) ? '0 : cur_idx + PTR_W'(1);
      done_hit        = done[cur_idx] && (state == ST_SERVE);

      if (active_start && (state != ST_IDLE)) begin
         state_nxt   = ST_IDLE;
         grant_nxt   = '0;
         pending_nxt = '0;
         if (state == ST_SERVE) begin
            if (done_hit) begin
               remain     = pending & ~cur_mask;
               rr_ptr_nxt = idx_inc;
            end else begin
               rr_ptr_nxt = cur_idx;
            end
         end
         overrun_nxt = |remain;
      end else begin
         case (state)
            ST_IDLE: begin
               if (blank_start && !active_start) begin
                  pending_nxt     = req;
                  frame_count_nxt = frame_count + CNT_W'(1);
                  frame_tick_nxt  = 1'b1;
                  state_nxt       = ST_ARB;
               end
            end
            ST_ARB: begin
               if (pick_valid) begin
                  grant_nxt   = N_REQ'(onehot(8'(pick_idx)));
                  cur_idx_nxt = pick_idx;
                  timer_nxt   = '0;
                  state_nxt   = ST_SERVE;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_SERVE: begin
               if (done_hit || (timer == TMR_W'(TIMEOUT_CYCLES - 1))) begin
                  grant_nxt   = '0;
                  pending_nxt = pending & ~cur_mask;
                  rr_ptr_nxt  = idx_inc;
                  timeout_nxt = !done_hit;
                  state_nxt   = ST_ARB;
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      busy_nxt   = (state_nxt != ST_IDLE);
      sticky_nxt = overrun_nxt | (overrun_sticky & ~clear_sticky);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         pending        <= '0;
         rr_ptr         <= '0;
         cur_idx        <= '0;
         timer          <= '0;
         grant          <= '0;
         frame_tick     <= 1'b0;
         frame_count    <= '0;
         busy           <= 1'b0;
         timeout        <= 1'b0;
         overrun        <= 1'b0;
         overrun_sticky <= 1'b0;
      end else begin
         state          <= state_nxt;
         pending        <= pending_nxt;
         rr_ptr         <= rr_ptr_nxt;
         cur_idx        <= cur_idx_nxt;
         timer          <= timer_nxt;
         grant          <= grant_nxt;
         frame_tick     <= frame_tick_nxt;
         frame_count    <= frame_count_nxt;
         busy           <= busy_nxt;
         timeout        <= timeout_nxt;
         overrun        <= overrun_nxt;
         overrun_sticky <= sticky_nxt;
      end
   end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Bench for frame_update_scheduler: each frame is planned as a grant timeline
// from the round-robin/timeout/abort rules, then driven and compared cycle by cycle.
module tb_frame_update_scheduler;

   localparam int N    = 4;
   localparam int T    = 8;
   localparam int CW   = 4;
   localparam int FLEN = 48;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          blank_start, active_start, clear_sticky;
   logic [N-1:0]  req, done, grant;
   logic          frame_tick, busy, timeout, overrun, overrun_sticky;
   logic [CW-1:0] frame_count;

   int total = 0;
   int bad   = 0;

   // Reference state carried between frames.
   int m_rr;
   int m_fc;
   bit m_sticky;

   // Per-cycle plan of one frame (index = cycle after the blank_start cycle).
   logic [N-1:0] eg     [FLEN+1];
   bit           eb     [FLEN+1];
   bit           ef     [FLEN+1];
   bit           et     [FLEN+1];
   bit           eo     [FLEN+1];
   logic [N-1:0] done_d [FLEN+1];
   bit           blk_d  [FLEN+1];
   bit           act_d  [FLEN+1];
   bit           clr_d  [FLEN+1];

   always #5 clk = ~clk;

   frame_update_scheduler #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (T),
      .CNT_W          (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .blank_start    (blank_start),
      .active_start   (active_start),
      .req            (req),
      .done           (done),
      .clear_sticky   (clear_sticky),
      .grant          (grant),
      .frame_tick     (frame_tick),
      .frame_count    (frame_count),
      .busy           (busy),
      .timeout        (timeout),
      .overrun        (overrun),
      .overrun_sticky (overrun_sticky)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [N-1:0] p, input int rr);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (rr + k) % N;
         if (p[j]) return j;
      end
      return -1;
   endfunction

   task automatic check_all_zero(input string pfx);
      chk({pfx, "_grant"}, 32'(grant), 32'(0));
      chk({pfx, "_tick"}, 32'(frame_tick), 32'(0));
      chk({pfx, "_fc"}, 32'(frame_count), 32'(0));
      chk({pfx, "_busy"}, 32'(busy), 32'(0));
      chk({pfx, "_timeout"}, 32'(timeout), 32'(0));
      chk({pfx, "_overrun"}, 32'(overrun), 32'(0));
      chk({pfx, "_sticky"}, 32'(overrun_sticky), 32'(0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      blank_start = 1'b0; active_start = 1'b0; done = '0; clear_sticky = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      m_rr = 0; m_fc = 0; m_sticky = 1'b0;
      step();
   endtask

   // noise: 0 = clean, 1 = random stray inputs, 2 = saturate ignored inputs
   task automatic run_frame(input logic [N-1:0] r, input int d0, input int d1,
                            input int d2, input int d3, input int abort_at,
                            input int clr_at, input int noise);
      int           d [N];
      logic [N-1:0] pend, bit_i;
      int           arb, g, e, i;
      bit           fin, tmo, hit;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int c = 0; c <= FLEN; c++) begin
         eg[c] = '0; eb[c] = 1'b0; ef[c] = 1'b0; et[c] = 1'b0; eo[c] = 1'b0;
         done_d[c] = '0; blk_d[c] = 1'b0; act_d[c] = 1'b0; clr_d[c] = 1'b0;
      end
      ef[1] = 1'b1;
      pend  = r;
      arb   = 1;
      fin   = 1'b0;
      while (!fin) begin
         eb[arb] = 1'b1;
         if (abort_at == arb) begin
            eo[arb+1] = (pend != '0);
            fin = 1'b1;
         end else if (pend == '0) begin
            fin = 1'b1;
         end else begin
            i     = pick(pend, m_rr);
            bit_i = N'(1) << i;
            g     = arb + 1;
            tmo   = (d[i] >= T);
            e     = tmo ? g + T - 1 : g + d[i];
            for (int c = g; c <= e; c++) begin
               if (!fin) begin
                  eg[c] = bit_i;
                  eb[c] = 1'b1;
                  if (c == abort_at) begin
                     hit = (c == e) && !tmo;
                     if (hit) done_d[c] = done_d[c] | bit_i;
                     eo[c+1] = ((pend & ~(hit ? bit_i : '0)) != '0);
                     m_rr = hit ? (i + 1) % N : i;
                     fin = 1'b1;
                  end
               end
            end
            if (!fin) begin
               if (!tmo) done_d[e] = done_d[e] | bit_i;
               pend    = pend & ~bit_i;
               m_rr    = (i + 1) % N;
               et[e+1] = tmo;
               arb     = e + 1;
            end
         end
      end
      for (int c = 1; c < FLEN - 1; c++) begin
         if (noise == 2) begin
            done_d[c] = done_d[c] | ~eg[c];
            blk_d[c]  = eb[c];
         end else if (noise == 1) begin
            if ($urandom_range(0, 3) == 0) done_d[c] = done_d[c] | (N'($urandom_range(0, 15)) & ~eg[c]);
            blk_d[c] = eb[c] && ($urandom_range(0, 7) == 0);
            act_d[c] = !eb[c] && ($urandom_range(0, 7) == 0);
            clr_d[c] = ($urandom_range(0, 7) == 0);
         end
      end
      if (abort_at >= 0) act_d[abort_at] = 1'b1;
      if (clr_at >= 0) clr_d[clr_at] = 1'b1;

      for (int c = 0; c < FLEN; c++) begin
         if (c == 1) m_fc = (m_fc + 1) % (1 << CW);
         if (c > 0) m_sticky = eo[c] ? 1'b1 : (clr_d[c-1] ? 1'b0 : m_sticky);
         chk($sformatf("grant@%0d", c), 32'(grant), 32'(eg[c]));
         chk($sformatf("busy@%0d", c), 32'(busy), 32'(eb[c]));
         chk($sformatf("tick@%0d", c), 32'(frame_tick), 32'(ef[c]));
         chk($sformatf("timeout@%0d", c), 32'(timeout), 32'(et[c]));
         chk($sformatf("overrun@%0d", c), 32'(overrun), 32'(eo[c]));
         chk($sformatf("sticky@%0d", c), 32'(overrun_sticky), 32'(m_sticky));
         chk($sformatf("fcount@%0d", c), 32'(frame_count), 32'(m_fc));
         blank_start  = (c == 0) || blk_d[c];
         active_start = act_d[c];
         done         = done_d[c];
         clear_sticky = clr_d[c];
         req          = (c == 0 || noise == 0) ? r : N'($urandom_range(0, 15));
         step();
      end
      blank_start = 1'b0; active_start = 1'b0; done = '0; clear_sticky = 1'b0;
   endtask

   initial begin
      int dr [N];
      int ab;
      rst_n = 1'b0;
      blank_start = 1'b0; active_start = 1'b0; clear_sticky = 1'b0;
      req = '0; done = '0;
      m_rr = 0; m_fc = 0; m_sticky = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Basic sequence: grants 0, 1, 3 with a gap between each.
      run_frame(4'b1011, 3, 3, 3, 3, -1, -1, 0);
      chk("basic_fc", 32'(frame_count), 32'(1));

      // Unit 0 never completes: timeout, then unit 1; next frame order follows rr.
      run_frame(4'b0011, 99, 2, 0, 0, -1, -1, 0);
      run_frame(4'b0011, 2, 2, 0, 0, -1, -1, 0);

      // Overrun during unit 2, restart at unit 2, clear, then clear racing a new set.
      do_reset();
      run_frame(4'b1111, 3, 3, 3, 3, 13, -1, 0);
      chk("ovr_sticky_set", 32'(overrun_sticky), 32'(1));
      run_frame(4'b1111, 1, 1, 1, 1, -1, 5, 0);
      chk("ovr_sticky_clr", 32'(overrun_sticky), 32'(0));
      run_frame(4'b1111, 3, 3, 3, 3, 13, 13, 0);
      chk("ovr_sticky_race", 32'(overrun_sticky), 32'(1));

      // Last done coincides with active_start: no overrun, next frame starts at 3.
      do_reset();
      run_frame(4'b0100, 0, 0, 3, 0, 5, -1, 0);
      chk("edge_no_ovr", 32'(overrun_sticky), 32'(0));
      run_frame(4'b1111, 1, 1, 1, 1, -1, -1, 0);

      // Stray done bits and blank_start while serving are ignored.
      run_frame(4'b0001, 5, 0, 0, 0, -1, -1, 2);
      run_frame(4'b1011, 2, 2, 2, 2, -1, -1, 2);

      // Asynchronous reset while unit 2 holds the grant.
      do_reset();
      req = 4'b0100;
      blank_start = 1'b1;
      step();
      blank_start = 1'b0;
      step();
      chk("mid_grant", 32'(grant), 32'(4'b0100));
      step();
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_rr = 0; m_fc = 0; m_sticky = 1'b0;
      run_frame(4'b1111, 2, 2, 2, 2, -1, -1, 0);

      // Counter wrap with a 4-bit frame counter.
      do_reset();
      for (int f = 0; f < 17; f++) run_frame(4'b0000, 0, 0, 0, 0, -1, -1, 0);
      chk("wrap_fc", 32'(frame_count), 32'(1));

      // Randomised frames.
      for (int f = 0; f < 30; f++) begin
         for (int k = 0; k < N; k++) dr[k] = int'($urandom_range(0, 9));
         ab = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 40)) : -1;
         run_frame(N'($urandom_range(0, 15)), dr[0], dr[1], dr[2], dr[3], ab, -1, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
